// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I execute/fetch-sequencing slice:
// datapath width, ALUOp encodings and ALU control codes.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101
  } alu_ctrl_t;

endpackage

// File: rtl/riscv_alu_pc_unit_if.sv
// Bus bundle between the core's control/regfile side and the ALU/PC slice.
interface riscv_alu_pc_unit_if;
  import riscv_pkg::*;

  logic            pc_src;
  logic [XLEN-1:0] imm_ext;
  logic [1:0]      alu_op;
  logic [2:0]      func3;
  logic            op5;
  logic            func7_5;
  logic [XLEN-1:0] alu_in1;
  logic [XLEN-1:0] alu_in2;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_target;
  logic [2:0]      alu_control;
  logic [XLEN-1:0] alu_out;
  logic            z_flag;
  logic            c_flag;
  logic            ov_flag;

  modport slave (
    input  pc_src, imm_ext, alu_op, func3, op5, func7_5, alu_in1, alu_in2,
    output pc, pc_plus4, pc_target, alu_control, alu_out, z_flag, c_flag, ov_flag
  );

  modport master (
    output pc_src, imm_ext, alu_op, func3, op5, func7_5, alu_in1, alu_in2,
    input  pc, pc_plus4, pc_target, alu_control, alu_out, z_flag, c_flag, ov_flag
  );

endinterface

// File: rtl/riscv_alu_pc_unit_alu_core.sv
// 32-bit ALU datapath with zero/carry/overflow flags; sub and slt share one adder.
module riscv_alu_pc_unit_alu_core
  import riscv_pkg::*;
(
  input  logic [2:0]      alu_control,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            z_flag,
  output logic            c_flag,
  output logic            ov_flag
);

  logic            sub_mode;
  logic            arith;
  logic [XLEN-1:0] b_op;
  logic [XLEN:0]   sum;
  logic            overflow;

  // Shared adder: subtraction is a + ~b + 1, overflow judged on the inverted operand
  always_comb begin
    sub_mode = (alu_control == ALU_SUB) || (alu_control == ALU_SLT);
    arith    = sub_mode || (alu_control == ALU_ADD);
    b_op     = sub_mode ? ~b : b;
    sum      = {1'b0, a} + {1'b0, b_op} + {{XLEN{1'b0}}, sub_mode};
    overflow = (a[XLEN-1] == b_op[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
  end

  // Result select and flags
  always_comb begin
    result = {XLEN{1'b0}};
    case (alu_control)
      ALU_ADD: result = sum[XLEN-1:0];
      ALU_SUB: result = sum[XLEN-1:0];
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_SLT: result = {{(XLEN-1){1'b0}}, sum[XLEN-1] ^ overflow};
      default: result = {XLEN{1'b0}};
    endcase
    z_flag  = (result == {XLEN{1'b0}});
    c_flag  = arith & sum[XLEN];
    ov_flag = arith & overflow;
  end

endmodule

// File: rtl/riscv_alu_pc_unit_alu_ctrl_dec.sv
// ALU control decoder: maps ALUOp/funct3/funct7[5]/op[5] to a 3-bit ALU code.
module riscv_alu_pc_unit_alu_ctrl_dec
  import riscv_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] func3,
  input  logic       op5,
  input  logic       func7_5,
  output logic [2:0] alu_control
);

  // Decode; unlisted combinations fall back to add so the output is never X
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNC: begin
        case (func3)
          // bit30 only means sub for R-type; addi may carry it as immediate data
          3'b000: begin
            if (op5 & func7_5) begin
              alu_control = ALU_SUB;
            end else begin
              alu_control = ALU_ADD;
            end
          end
          3'b010:  alu_control = ALU_SLT;
          3'b100:  alu_control = ALU_XOR;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_alu_pc_unit.sv
// Execute/fetch-sequencing slice of the single-cycle RV32I core:
// PC register, next-PC adders, ALU control decoder and ALU.
module riscv_alu_pc_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input logic                clk,
  input logic                rst,
  riscv_alu_pc_unit_if.slave bus
);

  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_target;
  logic [XLEN-1:0] pc_next;

  // Next-PC arithmetic wraps silently modulo 2^XLEN
  always_comb begin
    pc_plus4  = pc_reg + XLEN'(32'd4);
    pc_target = pc_reg + bus.imm_ext;
    if (bus.pc_src) begin
      pc_next = pc_target;
    end else begin
      pc_next = pc_plus4;
    end
  end

  // Program counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg <= RESET_PC;
    end else begin
      pc_reg <= pc_next;
    end
  end

  assign bus.pc        = pc_reg;
  assign bus.pc_plus4  = pc_plus4;
  assign bus.pc_target = pc_target;

  riscv_alu_pc_unit_alu_ctrl_dec u_dec (
    .alu_op      (bus.alu_op),
    .func3       (bus.func3),
    .op5         (bus.op5),
    .func7_5     (bus.func7_5),
    .alu_control (bus.alu_control)
  );

  riscv_alu_pc_unit_alu_core u_alu (
    .alu_control (bus.alu_control),
    .a           (bus.alu_in1),
    .b           (bus.alu_in2),
    .result      (bus.alu_out),
    .z_flag      (bus.z_flag),
    .c_flag      (bus.c_flag),
    .ov_flag     (bus.ov_flag)
  );

endmodule

// File: tb/tb_riscv_alu_pc_unit.sv
// Directed self-checking bench for riscv_alu_pc_unit: PC sequencing, decoder and ALU.
module tb_riscv_alu_pc_unit;

  logic clk;
  logic rst;
  int   checks;
  int   fails;

  riscv_alu_pc_unit_if bus ();

  riscv_alu_pc_unit #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.pc !== 32'h0) begin fails++; $display("FAIL reset_async: got %h expected %h", bus.pc, 32'h0); end
    @(posedge clk); #1;
    checks++; if (bus.pc !== 32'h0) begin fails++; $display("FAIL reset_hold: got %h expected %h", bus.pc, 32'h0); end
  endtask

  task automatic test_sequencing();
    logic [31:0] exp;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      exp = 32'(k * 4);
      checks++; if (bus.pc !== exp) begin fails++; $display("FAIL seq_pc step %0d: got %h expected %h", k, bus.pc, exp); end
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.pc !== 32'h0) begin fails++; $display("FAIL reset_midrun: got %h expected %h", bus.pc, 32'h0); end
    @(posedge clk); #1;
    checks++; if (bus.pc !== 32'h0) begin fails++; $display("FAIL reset_midrun_hold: got %h expected %h", bus.pc, 32'h0); end
  endtask

  task automatic test_branch();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (bus.pc !== 32'h8) begin fails++; $display("FAIL branch_setup_pc: got %h expected %h", bus.pc, 32'h8); end
    bus.imm_ext = 32'hFFFF_FFF8;
    #1;
    checks++; if (bus.pc_plus4 !== 32'hC) begin fails++; $display("FAIL branch_pc_plus4: got %h expected %h", bus.pc_plus4, 32'hC); end
    checks++; if (bus.pc_target !== 32'h0) begin fails++; $display("FAIL branch_pc_target: got %h expected %h", bus.pc_target, 32'h0); end
    bus.pc_src = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.pc !== 32'h0) begin fails++; $display("FAIL branch_taken_pc: got %h expected %h", bus.pc, 32'h0); end
    // jump back to the top of the address space, then wrap through PC+4
    bus.imm_ext = 32'hFFFF_FFFC;
    #1;
    checks++; if (bus.pc_target !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_target: got %h expected %h", bus.pc_target, 32'hFFFF_FFFC); end
    @(posedge clk); #1;
    checks++; if (bus.pc !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_jump_pc: got %h expected %h", bus.pc, 32'hFFFF_FFFC); end
    bus.pc_src = 1'b0;
    #1;
    checks++; if (bus.pc_plus4 !== 32'h0) begin fails++; $display("FAIL wrap_pc_plus4: got %h expected %h", bus.pc_plus4, 32'h0); end
    @(posedge clk); #1;
    checks++; if (bus.pc !== 32'h0) begin fails++; $display("FAIL wrap_pc: got %h expected %h", bus.pc, 32'h0); end
  endtask

  task automatic test_decoder();
    logic [1:0] ops [0:9];
    logic [2:0] f3s [0:9];
    logic       o5s [0:9];
    logic       f7s [0:9];
    logic [2:0] exps[0:9];
    ops = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b11, 2'b10};
    f3s = '{3'b000, 3'b000, 3'b010, 3'b100, 3'b110, 3'b111, 3'b001, 3'b000, 3'b111, 3'b000};
    o5s = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    f7s = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exps = '{3'b001, 3'b000, 3'b101, 3'b100, 3'b011, 3'b010, 3'b000, 3'b001, 3'b000, 3'b000};
    for (int i = 0; i < 10; i++) begin
      bus.alu_op  = ops[i];
      bus.func3   = f3s[i];
      bus.op5     = o5s[i];
      bus.func7_5 = f7s[i];
      #1;
      checks++; if (bus.alu_control !== exps[i]) begin fails++; $display("FAIL decoder vec %0d: got %b expected %b", i, bus.alu_control, exps[i]); end
    end
  endtask

  task automatic test_add();
    bus.alu_op = 2'b00; bus.func3 = 3'b000; bus.op5 = 1'b0; bus.func7_5 = 1'b0;
    bus.alu_in1 = 32'h7FFF_FFFF; bus.alu_in2 = 32'h0000_0001;
    #1;
    checks++; if (bus.alu_out !== 32'h8000_0000) begin fails++; $display("FAIL add_ovf_result: got %h expected %h", bus.alu_out, 32'h8000_0000); end
    checks++; if ({bus.z_flag, bus.c_flag, bus.ov_flag} !== 3'b001) begin fails++; $display("FAIL add_ovf_flags zcv: got %b expected %b", {bus.z_flag, bus.c_flag, bus.ov_flag}, 3'b001); end
    bus.alu_in1 = 32'hFFFF_FFFF;
    #1;
    checks++; if (bus.alu_out !== 32'h0) begin fails++; $display("FAIL add_carry_result: got %h expected %h", bus.alu_out, 32'h0); end
    checks++; if ({bus.z_flag, bus.c_flag, bus.ov_flag} !== 3'b110) begin fails++; $display("FAIL add_carry_flags zcv: got %b expected %b", {bus.z_flag, bus.c_flag, bus.ov_flag}, 3'b110); end
  endtask

  task automatic test_sub_slt();
    bus.alu_op = 2'b01;
    bus.alu_in1 = 32'h5; bus.alu_in2 = 32'h5;
    #1;
    checks++; if (bus.alu_out !== 32'h0) begin fails++; $display("FAIL sub_eq_result: got %h expected %h", bus.alu_out, 32'h0); end
    checks++; if ({bus.z_flag, bus.c_flag, bus.ov_flag} !== 3'b110) begin fails++; $display("FAIL sub_eq_flags zcv: got %b expected %b", {bus.z_flag, bus.c_flag, bus.ov_flag}, 3'b110); end
    bus.alu_in1 = 32'h8000_0000; bus.alu_in2 = 32'h1;
    #1;
    checks++; if (bus.alu_out !== 32'h7FFF_FFFF) begin fails++; $display("FAIL sub_ovf_result: got %h expected %h", bus.alu_out, 32'h7FFF_FFFF); end
    checks++; if ({bus.z_flag, bus.c_flag, bus.ov_flag} !== 3'b011) begin fails++; $display("FAIL sub_ovf_flags zcv: got %b expected %b", {bus.z_flag, bus.c_flag, bus.ov_flag}, 3'b011); end
    bus.alu_op = 2'b10; bus.func3 = 3'b010; bus.op5 = 1'b1; bus.func7_5 = 1'b0;
    bus.alu_in1 = 32'hFFFF_FFFF; bus.alu_in2 = 32'h1;
    #1;
    checks++; if (bus.alu_out !== 32'h1) begin fails++; $display("FAIL slt_neg_pos: got %h expected %h", bus.alu_out, 32'h1); end
    checks++; if ({bus.z_flag, bus.c_flag, bus.ov_flag} !== 3'b010) begin fails++; $display("FAIL slt_neg_pos_flags zcv: got %b expected %b", {bus.z_flag, bus.c_flag, bus.ov_flag}, 3'b010); end
    bus.alu_in1 = 32'h1; bus.alu_in2 = 32'hFFFF_FFFF;
    #1;
    checks++; if (bus.alu_out !== 32'h0) begin fails++; $display("FAIL slt_pos_neg: got %h expected %h", bus.alu_out, 32'h0); end
    checks++; if ({bus.z_flag, bus.c_flag, bus.ov_flag} !== 3'b100) begin fails++; $display("FAIL slt_pos_neg_flags zcv: got %b expected %b", {bus.z_flag, bus.c_flag, bus.ov_flag}, 3'b100); end
    bus.alu_in1 = 32'h8000_0000; bus.alu_in2 = 32'h1;
    #1;
    checks++; if (bus.alu_out !== 32'h1) begin fails++; $display("FAIL slt_min_one: got %h expected %h", bus.alu_out, 32'h1); end
    checks++; if ({bus.z_flag, bus.c_flag, bus.ov_flag} !== 3'b011) begin fails++; $display("FAIL slt_min_one_flags zcv: got %b expected %b", {bus.z_flag, bus.c_flag, bus.ov_flag}, 3'b011); end
  endtask

  task automatic test_logic();
    logic [2:0]  f3s [0:2];
    logic [31:0] exps[0:2];
    f3s  = '{3'b111, 3'b110, 3'b100};
    exps = '{32'h00F0_00F0, 32'hFFF0_FFF0, 32'hFF00_FF00};
    bus.alu_op = 2'b10; bus.op5 = 1'b1; bus.func7_5 = 1'b0;
    bus.alu_in1 = 32'hF0F0_F0F0; bus.alu_in2 = 32'h0FF0_0FF0;
    for (int i = 0; i < 3; i++) begin
      bus.func3 = f3s[i];
      #1;
      checks++; if (bus.alu_out !== exps[i]) begin fails++; $display("FAIL logic_result func3=%b: got %h expected %h", f3s[i], bus.alu_out, exps[i]); end
      checks++; if ({bus.z_flag, bus.c_flag, bus.ov_flag} !== 3'b000) begin fails++; $display("FAIL logic_flags func3=%b zcv: got %b expected %b", f3s[i], {bus.z_flag, bus.c_flag, bus.ov_flag}, 3'b000); end
    end
  endtask

  initial begin
    checks      = 0;
    fails       = 0;
    clk         = 1'b0;
    rst         = 1'b0;
    bus.pc_src  = 1'b0;
    bus.imm_ext = 32'h0;
    bus.alu_op  = 2'b00;
    bus.func3   = 3'b000;
    bus.op5     = 1'b0;
    bus.func7_5 = 1'b0;
    bus.alu_in1 = 32'h0;
    bus.alu_in2 = 32'h0;
    test_reset();
    test_sequencing();
    test_branch();
    test_decoder();
    test_add();
    test_sub_slt();
    test_logic();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/riscv_alu_pc_unit.md
Name: riscv_alu_pc_unit

Overview:
- Execute/fetch-sequencing slice of the single-cycle RV32I core.
- Holds the program-counter register and computes next-PC: PC+4 or PC+immediate.
- Decodes ALUOp/funct3/funct7[5]/op[5] into a 3-bit ALU control.
- Performs the 32-bit ALU operation and produces zero/carry/overflow flags.
- Instruction memory, register file, main decoder and data memory sit outside.

Parameters:
- XLEN, 32, datapath width of PC, operands and result.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock; PC updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- pc_src  in  1  1 selects branch/jump target as next PC; 0 selects PC+4.
- imm_ext  in  XLEN  sign-extended immediate used for target computation.
- alu_op  in  2  ALUOp from main decoder.
- func3  in  3  instruction bits [14:12].
- op5  in  1  instruction bit [5]; 1 = R-type.
- func7_5  in  1  instruction bit [30].
- alu_in1  in  XLEN  operand A (register rs1).
- alu_in2  in  XLEN  operand B (rs2 or immediate, muxed outside).
- pc  out  XLEN  current program counter (registered).
- pc_plus4  out  XLEN  pc + 4, combinational.
- pc_target  out  XLEN  pc + imm_ext, combinational.
- alu_control  out  3  decoded ALU control.
- alu_out  out  XLEN  ALU result.
- z_flag  out  1  alu_out == 0.
- c_flag  out  1  carry out.
- ov_flag  out  1  signed overflow.

Behaviour:
- PC register:
  - rst high → pc = RESET_PC immediately, without waiting for a clock edge; held while rst is high.
  - Otherwise, on each posedge clk: pc ← (pc_src ? pc_target : pc_plus4).
  - Deasserting rst between edges → first update at the next posedge.
- Next-PC arithmetic: modulo 2^XLEN; wrap-around is silent (32'hFFFF_FFFC + 4 = 0).
- ALU decoder, combinational:
  - alu_op=00 → 000 (add).
  - alu_op=01 → 001 (sub).
  - alu_op=11 → 000 (add).
  - alu_op=10, decoded by func3:
    - 000 → 001 if (op5 & func7_5), else 000.
    - 010 → 101 (slt).
    - 100 → 100 (xor).
    - 110 → 011 (or).
    - 111 → 010 (and).
    - any other func3 → 000.
- ALU, combinational, by alu_control:
  - 000: a+b.
  - 001: a-b, computed as a + ~b + 1.
  - 010: a&b.
  - 011: a|b.
  - 100: a^b.
  - 101: slt = {31'b0, sum[31] ^ V} of the subtraction.
  - 110, 111: result 0.
- Flags:
  - z_flag = (alu_out == 0) for every control, including slt and the 110/111 codes.
  - c_flag = carry out of bit 31 for add, sub and slt; 0 otherwise. For sub, 1 means no borrow.
  - ov_flag = signed overflow for add, sub and slt; 0 otherwise.
    - add: a[31]==b[31] && sum[31]!=a[31].
    - sub: a[31]!=b[31] && diff[31]!=a[31].
- Only pc is sequential; all other outputs follow their inputs in the same cycle.
- No X propagation from the decoder; every input combination has a defined output.

Decomposition:
- Shared package riscv_pkg holds:
  - XLEN;
  - ALUOp encodings: ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNC=10;
  - ALU control codes: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT.
- Sub-modules:
  - alu_core: datapath and flags.
  - alu_ctrl_dec: decoder.
  - The PC register and adders stay in the top.

Test Plan:
- Reset and sequencing:
  - Assert rst at t=2ns, between clock edges → pc=0 before the next edge.
  - Release rst, pc_src=0 → pc reads 4, 8, 12 on successive edges.
  - Reassert rst mid-run → pc=0 at once.
- Branch target: pc=8, imm_ext=32'hFFFF_FFF8, pc_src=1 → next edge pc=0. Also check pc_plus4=12 and pc_target=0 before that edge.
- Decoder sweep:
  - alu_op=10, func3=000, op5=1, func7_5=1 → 001.
  - Same but op5=0 (addi with bit30 set) → 000.
  - func3 010/100/110/111 → 101/100/011/010.
  - alu_op=01 → 001.
- Add flags:
  - 32'h7FFF_FFFF + 1 → 32'h8000_0000, ov=1, c=0, z=0.
  - 32'hFFFF_FFFF + 1 → 0, z=1, c=1, ov=0.
- Sub/slt:
  - 5-5 → 0, z=1, c=1.
  - 32'h8000_0000 - 1 → 32'h7FFF_FFFF, ov=1.
  - slt(-1, 1) → 1.
  - slt(1, -1) → 0.
  - slt(32'h8000_0000, 1) → 1, with overflow in the internal subtraction.
- Logic ops: a=32'hF0F0_F0F0, b=32'h0FF0_0FF0:
  - and → 32'h00F0_00F0.
  - or → 32'hFFF0_FFF0.
  - xor → 32'hFF00_FF00.
  - c=0 and ov=0 in all three cases.
